assoc_cache_ctrl: RTL and testbench

//   Parametrised N-way set-associative, write-back, write-allocate cache controller with true-LRU replacement.

---
 rtl/assoc_cache_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_assoc_cache_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_cache_ctrl.sv
// N-way set-associative, write-back, write-allocate cache controller with true-LRU replacement.
// Optional statistics counters are built when CACHE_STATS_EN is defined.
module assoc_cache_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int NUM_SETS       = 16,
  parameter int WAYS           = 4,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              hit,
  output logic              miss,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_wbacks
);

  localparam int OFF_W  = $clog2(DATA_W / 8);
  localparam int WORD_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int LA_W   = ADDR_W - OFF_W;
  localparam int TAG_W  = LA_W - WORD_W - IDX_W;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_LINE - 1);
  localparam logic [WORD_W-1:0] WORD_ONE  = WORD_W'(1);
  localparam logic [WAY_W-1:0]  OLDEST    = WAY_W'(WAYS - 1);
  localparam logic [WAY_W-1:0]  AGE_ONE   = WAY_W'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WRITEBACK = 3'd2,
    S_REFILL    = 3'd3,
    S_RESPOND   = 3'd4
  } state_t;

  state_t state_r, state_nx_s;

  logic [TAG_W-1:0]  tag_r   [NUM_SETS][WAYS];
  logic              valid_r [NUM_SETS][WAYS];
  logic              dirty_r [NUM_SETS][WAYS];
  logic [WAY_W-1:0]  age_r   [NUM_SETS][WAYS];
  logic [DATA_W-1:0] data_r  [NUM_SETS][WAYS][WORDS_PER_LINE];

  logic [LA_W-1:0]   addr_r;
  logic [DATA_W-1:0] wdata_r, read_data_r, mem_wdata_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              op_wr_r, busy_r, done_r, hit_r, miss_r, mem_req_r, mem_we_r;
  logic [WAY_W-1:0]  victim_r;
  logic [WORD_W-1:0] cnt_r;

  logic [TAG_W-1:0]  req_tag_s;
  logic [IDX_W-1:0]  req_idx_s;
  logic [WORD_W-1:0] req_word_s, cnt_nx_s;
  logic              accept_s, lookup_s, ack_s, last_s, fill_s, lru_en_s;
  logic              hit_s, inv_found_s, victim_dirty_s;
  logic [WAY_W-1:0]  hit_way_s, inv_way_s, old_way_s, victim_s, touch_way_s;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx,
                                                  input logic [WORD_W-1:0] word);
    return {tag, idx, word, {OFF_W{1'b0}}};
  endfunction

  assign req_tag_s   = addr_r[LA_W-1 -: TAG_W];
  assign req_idx_s   = addr_r[WORD_W +: IDX_W];
  assign req_word_s  = addr_r[WORD_W-1:0];
  assign accept_s    = (state_r == S_IDLE) && (read || write);
  assign lookup_s    = (state_r == S_LOOKUP);
  assign ack_s       = mem_req_r && mem_ack;
  assign last_s      = (cnt_r == LAST_WORD);
  assign cnt_nx_s    = cnt_r + WORD_ONE;
  assign fill_s      = (state_r == S_REFILL) && ack_s && last_s;
  assign lru_en_s    = (lookup_s && hit_s) || fill_s;
  assign touch_way_s = lookup_s ? hit_way_s : victim_r;

  // Tag match, lowest invalid way and oldest way of the addressed set
  always_comb begin
    hit_s       = 1'b0;
    hit_way_s   = {WAY_W{1'b0}};
    inv_found_s = 1'b0;
    inv_way_s   = {WAY_W{1'b0}};
    old_way_s   = {WAY_W{1'b0}};
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_s       = hit_s | (valid_r[req_idx_s][w] && (tag_r[req_idx_s][w] == req_tag_s));
      hit_way_s   = (valid_r[req_idx_s][w] && (tag_r[req_idx_s][w] == req_tag_s)) ? WAY_W'(w) : hit_way_s;
      inv_found_s = inv_found_s | !valid_r[req_idx_s][w];
      inv_way_s   = !valid_r[req_idx_s][w] ? WAY_W'(w) : inv_way_s;
      old_way_s   = (age_r[req_idx_s][w] == OLDEST) ? WAY_W'(w) : old_way_s;
    end
    victim_s       = inv_found_s ? inv_way_s : old_way_s;
    victim_dirty_s = valid_r[req_idx_s][victim_s] && dirty_r[req_idx_s][victim_s];
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE:      if (accept_s) state_nx_s = S_LOOKUP; else state_nx_s = S_IDLE;
      S_LOOKUP:    if (hit_s) state_nx_s = S_IDLE;
                   else if (victim_dirty_s) state_nx_s = S_WRITEBACK;
                   else state_nx_s = S_REFILL;
      S_WRITEBACK: if (ack_s && last_s) state_nx_s = S_REFILL; else state_nx_s = S_WRITEBACK;
      S_REFILL:    if (ack_s && last_s) state_nx_s = S_RESPOND; else state_nx_s = S_REFILL;
      S_RESPOND:   state_nx_s = S_IDLE;
      default:     state_nx_s = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= S_IDLE;
    else        state_r <= state_nx_s;
  end

  // Request latch, CPU handshake outputs and memory burst sequencing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_r      <= {LA_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      op_wr_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      hit_r       <= 1'b0;
      miss_r      <= 1'b0;
      read_data_r <= {DATA_W{1'b0}};
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      victim_r    <= {WAY_W{1'b0}};
      cnt_r       <= {WORD_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      hit_r  <= 1'b0;
      miss_r <= 1'b0;
      case (state_r)
        S_IDLE: if (accept_s) begin
          addr_r  <= address[ADDR_W-1:OFF_W];
          wdata_r <= write_data;
          op_wr_r <= write;
          busy_r  <= 1'b1;
        end
        S_LOOKUP: if (hit_s) begin
          done_r <= 1'b1;
          hit_r  <= 1'b1;
          busy_r <= 1'b0;
          if (!op_wr_r) read_data_r <= data_r[req_idx_s][hit_way_s][req_word_s];
        end else begin
          miss_r    <= 1'b1;
          victim_r  <= victim_s;
          cnt_r     <= {WORD_W{1'b0}};
          mem_req_r <= 1'b1;
          mem_we_r  <= victim_dirty_s;
          if (victim_dirty_s) begin
            mem_addr_r  <= line_addr(tag_r[req_idx_s][victim_s], req_idx_s, {WORD_W{1'b0}});
            mem_wdata_r <= data_r[req_idx_s][victim_s][0];
          end else begin
            mem_addr_r  <= line_addr(req_tag_s, req_idx_s, {WORD_W{1'b0}});
          end
        end
        S_WRITEBACK: if (ack_s) begin
          if (last_s) begin
            mem_we_r   <= 1'b0;
            cnt_r      <= {WORD_W{1'b0}};
            mem_addr_r <= line_addr(req_tag_s, req_idx_s, {WORD_W{1'b0}});
          end else begin
            cnt_r       <= cnt_nx_s;
            mem_addr_r  <= line_addr(tag_r[req_idx_s][victim_r], req_idx_s, cnt_nx_s);
            mem_wdata_r <= data_r[req_idx_s][victim_r][cnt_nx_s];
          end
        end
        S_REFILL: if (ack_s) begin
          if (last_s) begin
            mem_req_r <= 1'b0;
          end else begin
            cnt_r      <= cnt_nx_s;
            mem_addr_r <= line_addr(req_tag_s, req_idx_s, cnt_nx_s);
          end
        end
        S_RESPOND: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
          if (!op_wr_r) read_data_r <= data_r[req_idx_s][victim_r][req_word_s];
        end
        default: busy_r <= 1'b0;
      endcase
    end
  end

  // Line state: valid/dirty flags and LRU ages (ages stay a permutation per set)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_r[s][w] <= 1'b0;
          dirty_r[s][w] <= 1'b0;
          age_r[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      if (lookup_s && hit_s && op_wr_r) dirty_r[req_idx_s][hit_way_s] <= 1'b1;
      if (fill_s) begin
        valid_r[req_idx_s][victim_r] <= 1'b1;
        dirty_r[req_idx_s][victim_r] <= 1'b0;
      end
      if ((state_r == S_RESPOND) && op_wr_r) dirty_r[req_idx_s][victim_r] <= 1'b1;
      if (lru_en_s) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == touch_way_s) age_r[req_idx_s][w] <= {WAY_W{1'b0}};
          else if (age_r[req_idx_s][w] < age_r[req_idx_s][touch_way_s])
            age_r[req_idx_s][w] <= age_r[req_idx_s][w] + AGE_ONE;
        end
      end
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set
  always_ff @(posedge clk) begin
    if (lookup_s && hit_s && op_wr_r) data_r[req_idx_s][hit_way_s][req_word_s] <= wdata_r;
    if ((state_r == S_REFILL) && ack_s) data_r[req_idx_s][victim_r][cnt_r] <= mem_rdata;
    if (fill_s) tag_r[req_idx_s][victim_r] <= req_tag_s;
    if ((state_r == S_RESPOND) && op_wr_r) data_r[req_idx_s][victim_r][req_word_s] <= wdata_r;
  end

  assign read_data = read_data_r;
  assign hit       = hit_r;
  assign miss      = miss_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

`ifdef CACHE_STATS_EN
  logic [31:0] hits_r, misses_r, wbacks_r;

  // Event counters, wrapping at 2^32
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hits_r   <= 32'd0;
      misses_r <= 32'd0;
      wbacks_r <= 32'd0;
    end else begin
      if (lookup_s && hit_s) hits_r <= hits_r + 32'd1;
      if (lookup_s && !hit_s) misses_r <= misses_r + 32'd1;
      if (lookup_s && !hit_s && victim_dirty_s) wbacks_r <= wbacks_r + 32'd1;
    end
  end

  assign stat_hits   = hits_r;
  assign stat_misses = misses_r;
  assign stat_wbacks = wbacks_r;
`else
  assign stat_hits   = 32'd0;
  assign stat_misses = 32'd0;
  assign stat_wbacks = 32'd0;
`endif

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Table-driven bench for assoc_cache_ctrl with a latency-configurable backing memory model
// (refill data = 0x1000 + word address).
module tb_assoc_cache_ctrl;
  logic        clk = 1'b0, reset = 1'b0, read = 1'b0, write = 1'b0;
  logic [31:0] address = 32'd0, write_data = 32'd0, read_data;
  logic        hit, miss, busy, done, mem_req, mem_we, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'd0;
  logic [31:0] stat_hits, stat_misses, stat_wbacks;

`ifdef CACHE_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  assoc_cache_ctrl dut (
    .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
    .write_data(write_data), .read_data(read_data), .hit(hit), .miss(miss),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .stat_hits(stat_hits), .stat_misses(stat_misses),
    .stat_wbacks(stat_wbacks)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: one log entry per acknowledged word; request must stay stable while stalled
  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } mem_ev_t;
  mem_ev_t     log_q[$];
  int          ack_delay = 0, wait_cnt = 0;
  logic        snap_we;
  logic [31:0] snap_addr, snap_data;

  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req === 1'b1) begin
      if (wait_cnt == 0) begin
        snap_we = mem_we; snap_addr = mem_addr; snap_data = mem_wdata;
      end else begin
        chk("stall mem_addr", mem_addr, snap_addr);
        chk("stall mem_we", {31'd0, mem_we}, {31'd0, snap_we});
        chk("stall mem_wdata", mem_wdata, snap_data);
      end
      if (wait_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'h1000 + (mem_addr >> 2);
        log_q.push_back('{mem_we, mem_addr, mem_wdata});
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output logic h, output logic m, output logic [31:0] rdat, output int lat);
    @(negedge clk);
    read = rd; write = wr; address = a; write_data = d;
    lat = 0; m = 1'b0;
    do begin
      @(negedge clk);
      read = 1'b0; write = 1'b0; lat++;
      if (miss === 1'b1) m = 1'b1;
      if (done !== 1'b1) chk("busy during access", {31'd0, busy}, 32'd1);
    end while (done !== 1'b1 && lat < 500);
    chk("done reached", {31'd0, done}, 32'd1);
    chk("busy low at done", {31'd0, busy}, 32'd0);
    h = hit; rdat = read_data;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst stat_misses", stat_misses, 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic rd, wr; logic [31:0] addr, wdata; logic rst_before;
    logic exp_hit, exp_miss, chk_rdata; logic [31:0] exp_rdata;
    int exp_nrd, exp_nwr; logic [31:0] wb_base; logic [3:0][31:0] wb_data;
    logic chk_stats; int s_hits, s_miss, s_wb;
  } vec_t;

  function automatic vec_t mk(logic rd, logic wr, logic [31:0] a, logic [31:0] d, logic rst,
                              logic eh, logic em, logic cr, logic [31:0] er, int nrd, int nwr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = d; v.rst_before = rst;
    v.exp_hit = eh; v.exp_miss = em; v.chk_rdata = cr; v.exp_rdata = er;
    v.exp_nrd = nrd; v.exp_nwr = nwr; v.wb_base = 32'd0; v.wb_data = {4{32'd0}};
    v.chk_stats = 1'b0; v.s_hits = 0; v.s_miss = 0; v.s_wb = 0;
    return v;
  endfunction

  vec_t vecs[19];

  initial begin
    logic        h, m;
    logic [31:0] rdat, line;
    int          lat, nrd, nwr, n;

    // write-miss/refill/hit, then dirty write-back of line 0x000
    vecs[0]  = mk(1'b0, 1'b1, 32'h0004, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 4, 0);
    vecs[1]  = mk(1'b1, 1'b0, 32'h0004, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 0, 0);
    vecs[2]  = mk(1'b1, 1'b0, 32'h0008, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1002, 0, 0);
    vecs[3]  = mk(1'b1, 1'b0, 32'h0100, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1040, 4, 0);
    vecs[4]  = mk(1'b1, 1'b0, 32'h0200, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1080, 4, 0);
    vecs[5]  = mk(1'b1, 1'b0, 32'h0300, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10C0, 4, 0);
    vecs[6]  = mk(1'b1, 1'b0, 32'h0400, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1100, 4, 4);
    vecs[6].wb_data = {32'h1003, 32'h1002, 32'hDEADBEEF, 32'h1000};
    vecs[6].chk_stats = 1'b1; vecs[6].s_hits = 2; vecs[6].s_miss = 5; vecs[6].s_wb = 1;
    // clean LRU eviction from a fresh cache
    vecs[7]  = mk(1'b1, 1'b0, 32'h0000, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1000, 4, 0);
    vecs[8]  = mk(1'b1, 1'b0, 32'h0100, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1040, 4, 0);
    vecs[9]  = mk(1'b1, 1'b0, 32'h0200, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1080, 4, 0);
    vecs[10] = mk(1'b1, 1'b0, 32'h0300, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10C0, 4, 0);
    vecs[11] = mk(1'b1, 1'b0, 32'h0000, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1000, 0, 0);
    vecs[12] = mk(1'b1, 1'b0, 32'h0400, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1100, 4, 0);
    vecs[13] = mk(1'b1, 1'b0, 32'h0100, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1040, 4, 0);
    vecs[14] = mk(1'b1, 1'b0, 32'h0000, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1000, 0, 0);
    // read+write together acts as a write; unaligned offset ignored
    vecs[15] = mk(1'b1, 1'b1, 32'h0020, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 4, 0);
    vecs[16] = mk(1'b1, 1'b0, 32'h0020, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678, 0, 0);
    vecs[17] = mk(1'b1, 1'b0, 32'h0024, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1009, 0, 0);
    vecs[18] = mk(1'b1, 1'b0, 32'h0026, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1009, 0, 0);

    repeat (3) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset hit", {31'd0, hit}, 32'd0);
    chk("reset miss", {31'd0, miss}, 32'd0);
    chk("reset mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset read_data", read_data, 32'd0);
    chk("reset stat_hits", stat_hits, 32'd0);
    chk("reset stat_wbacks", stat_wbacks, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].rst_before) apply_reset();
      log_q.delete();
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, h, m, rdat, lat);
      chk($sformatf("v%0d hit", i), {31'd0, h}, {31'd0, vecs[i].exp_hit});
      chk($sformatf("v%0d miss", i), {31'd0, m}, {31'd0, vecs[i].exp_miss});
      if (vecs[i].chk_rdata) chk($sformatf("v%0d read_data", i), rdat, vecs[i].exp_rdata);
      if (vecs[i].exp_hit) chk($sformatf("v%0d hit latency", i), lat, 32'd2);
      nrd = 0; nwr = 0;
      line = vecs[i].addr & 32'hFFFF_FFF0;
      for (int k = 0; k < log_q.size(); k++) begin
        chk($sformatf("v%0d mem_we order %0d", i, k), {31'd0, log_q[k].we}, (k < vecs[i].exp_nwr) ? 32'd1 : 32'd0);
        if (log_q[k].we) begin
          chk($sformatf("v%0d wb addr %0d", i, k), log_q[k].addr, vecs[i].wb_base + 32'(4 * nwr));
          chk($sformatf("v%0d wb data %0d", i, k), log_q[k].data, vecs[i].wb_data[nwr[1:0]]);
          nwr++;
        end else begin
          chk($sformatf("v%0d refill addr %0d", i, k), log_q[k].addr, line + 32'(4 * nrd));
          nrd++;
        end
      end
      chk($sformatf("v%0d refill reads", i), nrd, vecs[i].exp_nrd);
      chk($sformatf("v%0d write-backs", i), nwr, vecs[i].exp_nwr);
      if (vecs[i].chk_stats) begin
        chk("stat_hits", stat_hits, STATS_ON ? 32'(vecs[i].s_hits) : 32'd0);
        chk("stat_misses", stat_misses, STATS_ON ? 32'(vecs[i].s_miss) : 32'd0);
        chk("stat_wbacks", stat_wbacks, STATS_ON ? 32'(vecs[i].s_wb) : 32'd0);
      end
    end

    // Stall: each word acknowledged 5 cycles late; victim is the clean 0x300 line
    ack_delay = 5;
    log_q.delete();
    access(1'b1, 1'b0, 32'h0500, 32'd0, h, m, rdat, lat);
    chk("stall miss", {31'd0, m}, 32'd1);
    chk("stall reads", log_q.size(), 32'd4);
    chk("stall read_data", rdat, 32'h1140);
    chk("stall latency >= 24", {31'd0, lat >= 24}, 32'd1);
    ack_delay = 0;

    // Reset after the second refill word has been consumed
    ack_delay = 2;
    log_q.delete();
    @(negedge clk);
    read = 1'b1; address = 32'h0600;
    @(negedge clk);
    read = 1'b0;
    n = 0;
    while (log_q.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid-refill two acks seen", {31'd0, log_q.size() >= 2}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("mid-refill reset mem_req", {31'd0, mem_req}, 32'd0);
    chk("mid-refill reset busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    ack_delay = 0;
    log_q.delete();
    access(1'b1, 1'b0, 32'h0600, 32'd0, h, m, rdat, lat);
    chk("after reset miss", {31'd0, m}, 32'd1);
    chk("after reset hit", {31'd0, h}, 32'd0);
    chk("after reset read_data", rdat, 32'h1180);

    // Request presented while busy is ignored
    log_q.delete();
    @(negedge clk);
    read = 1'b1; address = 32'h0030;
    @(negedge clk);
    address = 32'h7000;
    n = 1;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    read = 1'b0;
    chk("busy-ignore done", {31'd0, done}, 32'd1);
    chk("busy-ignore read_data", read_data, 32'h100C);
    chk("busy-ignore reads", log_q.size(), 32'd4);
    for (int k = 0; k < log_q.size(); k++)
      chk($sformatf("busy-ignore addr %0d", k), log_q[k].addr, 32'h0030 + 32'(4 * k));
    @(negedge clk);
    chk("busy-ignore not accepted", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
